axis_route_tagger: RTL and testbench

AXIS_ROUTE_TAGGER -- requirements
Module: axis_route_tagger

---
 rtl/axis_route_tagger.sv | 155 +++++++++++++++
 tb/tb_axis_route_tagger.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_route_tagger.sv
// Packet route tagger: buffers an AXI-Stream packet and extracts a 32-bit
// destination from each packet's first beat into a parallel address stream.
`default_nettype none

module axis_route_tagger_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Extra pointer MSB separates a full ring from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
endmodule

module axis_route_tagger #(
  parameter int DATA_FIFO_DEPTH = 64,
  parameter int ADDR_FIFO_DEPTH = 4,
  parameter int DEST_LSB        = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] m_packet_axis_tdata,
  output logic [7:0]  m_packet_axis_tkeep,
  output logic        m_packet_axis_tvalid,
  output logic        m_packet_axis_tlast,
  input  logic        m_packet_axis_tready,
  output logic [31:0] m_addr_axis_tdata,
  output logic        m_addr_axis_tvalid,
  output logic        m_addr_axis_tlast,
  input  logic        m_addr_axis_tready,
  output logic [31:0] pkt_count
);
  typedef enum logic {HEAD = 1'b0, BODY = 1'b1} state_t;

  state_t      state;
  state_t      state_next;
  logic        ready_en;
  logic        in_accept;
  logic        pkt_pop;
  logic        addr_pop;
  logic        data_full;
  logic        data_empty;
  logic        addr_full;
  logic        addr_empty;
  logic [72:0] data_rd;

  // Handshakes: a beat moves only on a rising edge where tvalid and tready are
  // both 1; a source holds tvalid and its payload steady until that edge.
  assign in_accept = s_axis_tvalid && s_axis_tready;
  assign pkt_pop   = m_packet_axis_tvalid && m_packet_axis_tready;
  assign addr_pop  = m_addr_axis_tvalid && m_addr_axis_tready;

  // ready_en holds input acceptance off for the cycle following reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HEAD;
      ready_en  <= 1'b0;
      pkt_count <= '0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      if (in_accept && s_axis_tlast) pkt_count <= pkt_count + 32'd1;
    end
  end

  always_comb begin
    state_next = state;
    if (in_accept) begin
      case (state)
        HEAD: if (!s_axis_tlast) state_next = BODY;
        BODY: if (s_axis_tlast)  state_next = HEAD;
      endcase
    end
  end

  // Only the first beat of a packet needs room in the address FIFO.
  assign s_axis_tready = ready_en && !rst && !data_full && ((state == BODY) || !addr_full);

  axis_route_tagger_fifo #(
    .WIDTH (73),
    .DEPTH (DATA_FIFO_DEPTH)
  ) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_accept),
    .wr_data ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .full    (data_full),
    .rd_en   (pkt_pop),
    .rd_data (data_rd),
    .empty   (data_empty)
  );

  axis_route_tagger_fifo #(
    .WIDTH (32),
    .DEPTH (ADDR_FIFO_DEPTH)
  ) u_addr_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_accept && (state == HEAD)),
    .wr_data (s_axis_tdata[DEST_LSB+31:DEST_LSB]),
    .full    (addr_full),
    .rd_en   (addr_pop),
    .rd_data (m_addr_axis_tdata),
    .empty   (addr_empty)
  );

  assign m_packet_axis_tdata  = data_rd[72:9];
  assign m_packet_axis_tkeep  = data_rd[8:1];
  assign m_packet_axis_tlast  = data_rd[0];
  assign m_packet_axis_tvalid = !data_empty && !rst;
  assign m_addr_axis_tvalid   = !addr_empty && !rst;
  assign m_addr_axis_tlast    = 1'b1;
endmodule

`default_nettype wire

// File: tb/tb_axis_route_tagger.sv
// Directed and randomized bench for axis_route_tagger; a second instance with
// DEST_LSB=32 shares the stimulus to check the upper destination field.
module tb_axis_route_tagger;
  localparam int BEAT_BUDGET  = 400;
  localparam int DRAIN_BUDGET = 3000;
  localparam int N_RAND_PKTS  = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] m_packet_axis_tdata;
  logic [7:0]  m_packet_axis_tkeep;
  logic        m_packet_axis_tvalid;
  logic        m_packet_axis_tlast;
  logic        m_packet_axis_tready;
  logic [31:0] m_addr_axis_tdata;
  logic        m_addr_axis_tvalid;
  logic        m_addr_axis_tlast;
  logic        m_addr_axis_tready;
  logic [31:0] pkt_count;

  logic        s32_tready;
  logic [63:0] p32_tdata;
  logic [7:0]  p32_tkeep;
  logic        p32_tvalid;
  logic        p32_tlast;
  logic [31:0] a32_tdata;
  logic        a32_tvalid;
  logic        a32_tlast;
  logic [31:0] cnt32;

  logic [72:0] exp_q[$];
  logic [72:0] exp32_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_addr32_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          addr32_seen = 0;
  logic        in_head;
  logic [31:0] exp_pkts;
  bit          rand_pkt;
  bit          rand_addr;

  axis_route_tagger dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s_axis_tready),
    .m_packet_axis_tdata  (m_packet_axis_tdata),
    .m_packet_axis_tkeep  (m_packet_axis_tkeep),
    .m_packet_axis_tvalid (m_packet_axis_tvalid),
    .m_packet_axis_tlast  (m_packet_axis_tlast),
    .m_packet_axis_tready (m_packet_axis_tready),
    .m_addr_axis_tdata    (m_addr_axis_tdata),
    .m_addr_axis_tvalid   (m_addr_axis_tvalid),
    .m_addr_axis_tlast    (m_addr_axis_tlast),
    .m_addr_axis_tready   (m_addr_axis_tready),
    .pkt_count            (pkt_count)
  );

  axis_route_tagger #(.DEST_LSB(32)) dut32 (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s32_tready),
    .m_packet_axis_tdata  (p32_tdata),
    .m_packet_axis_tkeep  (p32_tkeep),
    .m_packet_axis_tvalid (p32_tvalid),
    .m_packet_axis_tlast  (p32_tlast),
    .m_packet_axis_tready (m_packet_axis_tready),
    .m_addr_axis_tdata    (a32_tdata),
    .m_addr_axis_tvalid   (a32_tvalid),
    .m_addr_axis_tlast    (a32_tlast),
    .m_addr_axis_tready   (m_addr_axis_tready),
    .pkt_count            (cnt32)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp32_q.delete();
    exp_addr_q.delete();
    exp_addr32_q.delete();
    in_head  = 1'b1;
    exp_pkts = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check_eq("rst_tready",      128'(s_axis_tready),        128'(0));
    check_eq("rst_pkt_valid",   128'(m_packet_axis_tvalid), 128'(0));
    check_eq("rst_addr_valid",  128'(m_addr_axis_tvalid),   128'(0));
    check_eq("rst_addr_tlast",  128'(m_addr_axis_tlast),    128'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check_eq("post_rst_tready",     128'(s_axis_tready),        128'(0));
    check_eq("post_rst_pkt_valid",  128'(m_packet_axis_tvalid), 128'(0));
    check_eq("post_rst_addr_valid", 128'(m_addr_axis_tvalid),   128'(0));
    check_eq("post_rst_addr_tlast", 128'(a32_tlast),            128'(1));
    check_eq("post_rst_pkt_count",  128'(pkt_count),            128'(0));
    @(posedge clk); #1;
  endtask

  // driver tasks
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, output int waited);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!s_axis_tready && waited < BEAT_BUDGET) begin
      waited++;
      @(negedge clk);
    end
    if (s_axis_tready) begin
      check_eq("tready32", 128'(s32_tready), 128'(1));
      exp_q.push_back({d, k, l});
      exp32_q.push_back({d, k, l});
      if (in_head) begin
        exp_addr_q.push_back(d[31:0]);
        exp_addr32_q.push_back(d[63:32]);
      end
      in_head = l;
      if (l) exp_pkts = exp_pkts + 32'd1;
    end else begin
      check_eq("accept_timeout", 128'(s_axis_tready), 128'(1));
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp32_q.size() != 0 || exp_addr_q.size() != 0 ||
            exp_addr32_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain_pkt",    128'(exp_q.size()),        128'(0));
    check_eq("drain_pkt32",  128'(exp32_q.size()),      128'(0));
    check_eq("drain_addr",   128'(exp_addr_q.size()),   128'(0));
    check_eq("drain_addr32", 128'(exp_addr32_q.size()), 128'(0));
  endtask

  task automatic ready_rand();
    forever begin
      @(posedge clk); #2;
      if (rand_pkt)  m_packet_axis_tready = 1'($urandom_range(0, 1));
      if (rand_addr) m_addr_axis_tready   = 1'($urandom_range(0, 1));
    end
  endtask

  // scoreboard: compares every completed output handshake with the expected queues
  task automatic monitor();
    logic [72:0] e;
    forever begin
      @(negedge clk);
      if (m_packet_axis_tvalid && m_packet_axis_tready) begin
        if (exp_q.size() == 0) check_eq("pkt_unexpected", 128'(m_packet_axis_tvalid), 128'(0));
        else begin
          e = exp_q.pop_front();
          check_eq("pkt_beat", 128'({m_packet_axis_tdata, m_packet_axis_tkeep, m_packet_axis_tlast}), 128'(e));
        end
      end
      if (p32_tvalid && m_packet_axis_tready) begin
        if (exp32_q.size() == 0) check_eq("pkt32_unexpected", 128'(p32_tvalid), 128'(0));
        else begin
          e = exp32_q.pop_front();
          check_eq("pkt32_beat", 128'({p32_tdata, p32_tkeep, p32_tlast}), 128'(e));
        end
      end
      if (m_addr_axis_tvalid && m_addr_axis_tready) begin
        if (exp_addr_q.size() == 0) check_eq("addr_unexpected", 128'(m_addr_axis_tvalid), 128'(0));
        else check_eq("addr", 128'(m_addr_axis_tdata), 128'(exp_addr_q.pop_front()));
      end
      if (a32_tvalid && m_addr_axis_tready) begin
        addr32_seen++;
        if (exp_addr32_q.size() == 0) check_eq("addr32_unexpected", 128'(a32_tvalid), 128'(0));
        else check_eq("addr32", 128'(a32_tdata), 128'(exp_addr32_q.pop_front()));
      end
    end
  endtask

  initial begin
    int w;
    int base;
    int fast;
    int len;
    rst                  = 1'b1;
    s_axis_tdata         = '0;
    s_axis_tkeep         = '0;
    s_axis_tvalid        = 1'b0;
    s_axis_tlast         = 1'b0;
    m_packet_axis_tready = 1'b0;
    m_addr_axis_tready   = 1'b0;
    rand_pkt             = 1'b0;
    rand_addr            = 1'b0;
    clear_model();
    fork
      monitor();
      ready_rand();
    join_none
    idle(2);
    do_reset();
    @(negedge clk);
    check_eq("ready_after_reset", 128'(s_axis_tready), 128'(1));
    @(posedge clk); #1;

    // single-beat packet, one-cycle visibility on both outputs
    m_packet_axis_tready = 1'b1;
    m_addr_axis_tready   = 1'b1;
    send_beat(64'h0000_0000_0000_0005, 8'hFF, 1'b1, w);
    check_eq("single_wait", 128'(w), 128'(0));
    @(negedge clk);
    check_eq("single_pkt_valid",  128'(m_packet_axis_tvalid), 128'(1));
    check_eq("single_pkt_data",   128'(m_packet_axis_tdata),  128'(64'h5));
    check_eq("single_pkt_last",   128'(m_packet_axis_tlast),  128'(1));
    check_eq("single_addr_valid", 128'(m_addr_axis_tvalid),   128'(1));
    check_eq("single_addr",       128'(m_addr_axis_tdata),    128'(32'h5));
    check_eq("single_addr32",     128'(a32_tdata),            128'(32'h0));
    check_eq("single_pkt_count",  128'(pkt_count),            128'(1));
    @(posedge clk); #1;
    wait_drain(DRAIN_BUDGET);

    // three-beat packet: upper destination field, one destination only
    base = addr32_seen;
    send_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, w);
    send_beat(64'h0000_0000_0000_0002, 8'hFF, 1'b0, w);
    send_beat(64'h0000_0000_0000_0003, 8'h0F, 1'b1, w);
    wait_drain(DRAIN_BUDGET);
    check_eq("three_beat_addr32_count", 128'(addr32_seen - base), 128'(1));

    // tlast beat with tkeep=0 passes untouched
    send_beat(64'hAAAA_5555_1234_5678, 8'hFF, 1'b0, w);
    send_beat(64'h0123_4567_89AB_CDEF, 8'h00, 1'b1, w);
    wait_drain(DRAIN_BUDGET);
    check_eq("count_after_directed", 128'(pkt_count), 128'(3));

    // address FIFO back-pressure
    m_addr_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(64'h0000_0000_0000_0010 + 64'(i), 8'hFF, 1'b1, w);
      check_eq("addrfull_accept_wait", 128'(w), 128'(0));
    end
    s_axis_tdata  = 64'h0000_0000_0000_0020;
    s_axis_tkeep  = 8'hFF;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("addrfull_stall", 128'(s_axis_tready), 128'(0));
    end
    @(posedge clk); #1;
    m_addr_axis_tready = 1'b1;
    send_beat(64'h0000_0000_0000_0020, 8'hFF, 1'b1, w);
    check_eq("addrfull_resume", 128'(w < 4), 128'(1));
    wait_drain(DRAIN_BUDGET);

    // data FIFO fill to 64 beats, then random drain across pointer wrap
    m_packet_axis_tready = 1'b0;
    fast = 0;
    for (int i = 0; i < 64; i++) begin
      send_beat(64'h7000_0000_0000_0000 + 64'(i), 8'hFF, 1'b0, w);
      if (w == 0) fast++;
    end
    check_eq("fill_accepted", 128'(fast), 128'(64));
    s_axis_tdata  = 64'h7000_0000_0000_0040;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("fill_stall", 128'(s_axis_tready), 128'(0));
    end
    @(posedge clk); #1;
    rand_pkt = 1'b1;
    for (int i = 64; i < 70; i++)
      send_beat(64'h7000_0000_0000_0000 + 64'(i), 8'hFF, 1'b1 && (i == 69), w);
    wait_drain(DRAIN_BUDGET);
    rand_pkt = 1'b0;
    m_packet_axis_tready = 1'b1;

    // reset in the middle of a packet
    m_packet_axis_tready = 1'b0;
    m_addr_axis_tready   = 1'b0;
    send_beat(64'h5555_0000_6666_0000, 8'hFF, 1'b0, w);
    send_beat(64'h0000_0000_0000_0099, 8'hFF, 1'b0, w);
    do_reset();
    m_packet_axis_tready = 1'b1;
    m_addr_axis_tready   = 1'b1;
    send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b1, w);
    wait_drain(DRAIN_BUDGET);
    check_eq("count_after_reset", 128'(pkt_count), 128'(1));

    // random traffic on every port
    rand_pkt  = 1'b1;
    rand_addr = 1'b1;
    for (int p = 0; p < N_RAND_PKTS; p++) begin
      len = int'($urandom_range(1, 16));
      for (int b = 0; b < len; b++) begin
        send_beat({$urandom, $urandom}, 8'($urandom), 1'b1 && (b == len - 1), w);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
    end
    wait_drain(DRAIN_BUDGET);
    rand_pkt  = 1'b0;
    rand_addr = 1'b0;
    check_eq("pkt_count_final",   128'(pkt_count), 128'(N_RAND_PKTS + 1));
    check_eq("pkt_count32_final", 128'(cnt32),     128'(exp_pkts));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
